// File: rtl/forwarding_scoreboard.sv
// Purpose: multi-lane operand forwarding select plus per-register busy scoreboard with stall counter.
// Latency: forward selects and src_stall are combinational; scoreboard and stall_count update on the next edge.
// Backpressure: none taken; src_stall is advisory only and never holds the scoreboard countdown.
module forwarding_scoreboard #(
    parameter int NUM_REGISTERS_LOG2 = 5,
    parameter int LANES              = 2,
    parameter int MAX_LAT            = 4,
    parameter int CW                 = $clog2(MAX_LAT + 1),
    parameter int FWD_W              = $clog2(2 * LANES + 1),
    parameter int FIRST_W            = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [LANES-1:0]                    issue_valid,
    input  logic [LANES*NUM_REGISTERS_LOG2-1:0] issue_rd,
    input  logic [LANES*CW-1:0]                 issue_lat,
    input  logic [LANES*NUM_REGISTERS_LOG2-1:0] id_ex_rs,
    input  logic [LANES*NUM_REGISTERS_LOG2-1:0] id_ex_rt,
    input  logic [LANES*NUM_REGISTERS_LOG2-1:0] ex_mem_rd,
    input  logic [LANES*NUM_REGISTERS_LOG2-1:0] mem_wb_rd,
    input  logic [LANES-1:0]                    ex_mem_reg_write,
    input  logic [LANES-1:0]                    mem_wb_reg_write,
    input  logic [FIRST_W-1:0]                  ex_mem_first,
    input  logic [FIRST_W-1:0]                  mem_wb_first,
    output logic [LANES*FWD_W-1:0]              forward_a,
    output logic [LANES*FWD_W-1:0]              forward_b,
    output logic [LANES-1:0]                    src_stall,
    output logic [15:0]                         stall_count
);

    localparam int RW   = NUM_REGISTERS_LOG2;
    localparam int NREG = 1 << RW;
    localparam logic [CW-1:0] LAT_CAP = CW'(MAX_LAT);

    // Busy countdown per architectural register; entry 0 is forced to zero.
    logic [CW-1:0] busy_q [NREG];
    logic [CW-1:0] busy_d [NREG];

    // Youngest lane in one stage writing src, walking oldest->youngest from first; -1 if none.
    function automatic int youngest_match(
        input logic [RW-1:0]       src,
        input logic [LANES*RW-1:0] rd_vec,
        input logic [LANES-1:0]    we_vec,
        input logic [FIRST_W-1:0]  first
    );
        int hit;
        int lane;
        hit = -1;
        for (int j = 0; j < LANES; j++) begin
            lane = (int'(first) + j) % LANES;
            if (src != '0 && we_vec[lane] && rd_vec[lane*RW +: RW] == src) begin
                hit = lane;
            end
        end
        return hit;
    endfunction

    // The nearer stage (ex_mem) always wins over mem_wb.
    function automatic logic [FWD_W-1:0] fwd_encode(input int ex_hit, input int wb_hit);
        logic [FWD_W-1:0] sel;
        sel = '0;
        if (ex_hit >= 0) begin
            sel = FWD_W'(1 + ex_hit);
        end else if (wb_hit >= 0) begin
            sel = FWD_W'(1 + LANES + wb_hit);
        end
        return sel;
    endfunction

    function automatic logic [CW-1:0] clamp_lat(input logic [CW-1:0] lat);
        return (lat > LAT_CAP) ? LAT_CAP : lat;
    endfunction

    // Per-lane forward selects for both source operands, purely from current inputs.
    always_comb begin
        forward_a = '0;
        forward_b = '0;
        for (int k = 0; k < LANES; k++) begin
            forward_a[k*FWD_W +: FWD_W] = fwd_encode(
                youngest_match(id_ex_rs[k*RW +: RW], ex_mem_rd, ex_mem_reg_write, ex_mem_first),
                youngest_match(id_ex_rs[k*RW +: RW], mem_wb_rd, mem_wb_reg_write, mem_wb_first));
            forward_b[k*FWD_W +: FWD_W] = fwd_encode(
                youngest_match(id_ex_rt[k*RW +: RW], ex_mem_rd, ex_mem_reg_write, ex_mem_first),
                youngest_match(id_ex_rt[k*RW +: RW], mem_wb_rd, mem_wb_reg_write, mem_wb_first));
        end
    end

    // Next scoreboard state: decrement, then issue loads (higher lane last so it wins), flush overrides all.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - CW'(1) : '0;
        end
        for (int k = 0; k < LANES; k++) begin
            if (issue_valid[k] && issue_rd[k*RW +: RW] != '0) begin
                busy_d[issue_rd[k*RW +: RW]] = clamp_lat(issue_lat[k*CW +: CW]);
            end
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                busy_d[r] = '0;
            end
        end
        busy_d[0] = '0;
    end

    // Scoreboard register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                busy_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

    // A lane stalls when either source still has a pending producer in registered state.
    always_comb begin
        src_stall = '0;
        for (int k = 0; k < LANES; k++) begin
            src_stall[k] = (busy_q[id_ex_rs[k*RW +: RW]] != '0) ||
                           (busy_q[id_ex_rt[k*RW +: RW]] != '0);
        end
    end

    // Saturating count of cycles in which any lane is stalled outside a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if ((|src_stall) && !flush && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed vectors, a ready-time model compared every cycle,
// plus literal expectations at the points the directed vectors were hand-computed for.
module tb_forwarding_scoreboard;

    localparam int RW      = 5;
    localparam int LANES   = 2;
    localparam int MAX_LAT = 4;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam int FW      = $clog2(2 * LANES + 1);
    localparam int FIRST_W = 1;
    localparam int NREG    = 1 << RW;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic [LANES-1:0]      issue_valid;
    logic [LANES*RW-1:0]   issue_rd;
    logic [LANES*CW-1:0]   issue_lat;
    logic [LANES*RW-1:0]   id_ex_rs;
    logic [LANES*RW-1:0]   id_ex_rt;
    logic [LANES*RW-1:0]   ex_mem_rd;
    logic [LANES*RW-1:0]   mem_wb_rd;
    logic [LANES-1:0]      ex_mem_reg_write;
    logic [LANES-1:0]      mem_wb_reg_write;
    logic [FIRST_W-1:0]    ex_mem_first;
    logic [FIRST_W-1:0]    mem_wb_first;
    logic [LANES*FW-1:0]   forward_a;
    logic [LANES*FW-1:0]   forward_b;
    logic [LANES-1:0]      src_stall;
    logic [15:0]           stall_count;

    forwarding_scoreboard #(
        .NUM_REGISTERS_LOG2(RW),
        .LANES(LANES),
        .MAX_LAT(MAX_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_lat(issue_lat),
        .id_ex_rs(id_ex_rs),
        .id_ex_rt(id_ex_rt),
        .ex_mem_rd(ex_mem_rd),
        .mem_wb_rd(mem_wb_rd),
        .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_reg_write(mem_wb_reg_write),
        .ex_mem_first(ex_mem_first),
        .mem_wb_first(mem_wb_first),
        .forward_a(forward_a),
        .forward_b(forward_b),
        .src_stall(src_stall),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
    endtask

    // ---------------- model ----------------
    // A register is busy while the current edge count is below the edge count at which its result lands.
    int ready_at [NREG];
    int cyc   = 0;
    int m_cnt = 0;

    function automatic int young(input int src, input logic [LANES*RW-1:0] rdv,
                                 input logic [LANES-1:0] we, input int first);
        int best = -1;
        int bage = -1;
        int age;
        if (src == 0) return -1;
        for (int l = 0; l < LANES; l++) begin
            if (we[l] && int'(rdv[l*RW +: RW]) == src) begin
                age = (l - first + LANES) % LANES;
                if (age > bage) begin
                    bage = age;
                    best = l;
                end
            end
        end
        return best;
    endfunction

    function automatic int m_sel(input int src);
        int e;
        int w;
        e = young(src, ex_mem_rd, ex_mem_reg_write, int'(ex_mem_first));
        w = young(src, mem_wb_rd, mem_wb_reg_write, int'(mem_wb_first));
        if (e >= 0) return 1 + e;
        if (w >= 0) return 1 + LANES + w;
        return 0;
    endfunction

    function automatic bit m_stall(input int k);
        return (ready_at[int'(id_ex_rs[k*RW +: RW])] > cyc) ||
               (ready_at[int'(id_ex_rt[k*RW +: RW])] > cyc);
    endfunction

    // Model state update at each edge (reset clears everything).
    always @(posedge clk or posedge reset) begin
        int  nr [NREG];
        int  nc;
        int  lat;
        int  rd;
        bit  any;
        if (reset) begin
            for (int r = 0; r < NREG; r++) nr[r] = 0;
            ready_at <= nr;
            m_cnt    <= 0;
        end else begin
            any = 0;
            for (int k = 0; k < LANES; k++) if (m_stall(k)) any = 1;
            nc = m_cnt;
            if (any && !flush && nc < 65535) nc = nc + 1;
            m_cnt <= nc;
            nr = ready_at;
            if (flush) begin
                for (int r = 0; r < NREG; r++) nr[r] = 0;
            end else begin
                for (int k = 0; k < LANES; k++) begin
                    rd  = int'(issue_rd[k*RW +: RW]);
                    lat = int'(issue_lat[k*CW +: CW]);
                    if (lat > MAX_LAT) lat = MAX_LAT;
                    if (issue_valid[k] && rd != 0) nr[rd] = cyc + 1 + lat;
                end
            end
            ready_at <= nr;
            cyc      <= cyc + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            chk("cyc_fwd_a", k, int'(forward_a[k*FW +: FW]), m_sel(int'(id_ex_rs[k*RW +: RW])));
            chk("cyc_fwd_b", k, int'(forward_b[k*FW +: FW]), m_sel(int'(id_ex_rt[k*RW +: RW])));
            chk("cyc_src_stall", k, int'(src_stall[k]), int'(m_stall(k)));
        end
        chk("cyc_stall_count", 0, int'(stall_count), m_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        flush            = 1'b0;
        issue_valid      = '0;
        issue_rd         = '0;
        issue_lat        = '0;
        id_ex_rs         = '0;
        id_ex_rt         = '0;
        ex_mem_rd        = '0;
        mem_wb_rd        = '0;
        ex_mem_reg_write = '0;
        mem_wb_reg_write = '0;
        ex_mem_first     = '0;
        mem_wb_first     = '0;
    endtask

    task automatic issue0(input int rd, input int lat);
        issue_valid[0]   = 1'b1;
        issue_rd[4:0]    = 5'(rd);
        issue_lat[CW-1:0] = CW'(lat);
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        #1;
        chk("rst_stall_count", 0, int'(stall_count), 0);
        chk("rst_src_stall", 0, int'(src_stall), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Both ex_mem lanes write r3, lane1 oldest -> lane0 youngest -> select 1.
        ex_mem_rd = {5'd3, 5'd3};
        ex_mem_reg_write = 2'b11;
        ex_mem_first = 1'b1;
        id_ex_rs = {5'd3, 5'd3};
        #1;
        chk("fwd_youngest_wrap", 0, int'(forward_a[2:0]), 1);
        chk("fwd_youngest_wrap", 1, int'(forward_a[5:3]), 1);
        ex_mem_first = 1'b0;
        #1;
        chk("fwd_youngest_lane1", 0, int'(forward_a[2:0]), 2);

        // ex_mem lane1 beats mem_wb lane0 on r5.
        clear_in();
        ex_mem_rd = {5'd5, 5'd0};
        ex_mem_reg_write = 2'b10;
        mem_wb_rd = {5'd0, 5'd5};
        mem_wb_reg_write = 2'b01;
        id_ex_rs = {5'd0, 5'd5};
        #1;
        chk("fwd_exmem_priority", 0, int'(forward_a[2:0]), 2);
        ex_mem_reg_write = 2'b00;
        #1;
        chk("fwd_memwb_only", 0, int'(forward_a[2:0]), 3);
        ex_mem_rd = '0;
        mem_wb_rd = '0;
        ex_mem_reg_write = 2'b11;
        mem_wb_reg_write = 2'b11;
        id_ex_rs = '0;
        #1;
        chk("fwd_r0_never", 0, int'(forward_a[2:0]), 0);
        clear_in();
        mem_wb_rd = {5'd6, 5'd6};
        mem_wb_reg_write = 2'b11;
        id_ex_rt = {5'd0, 5'd6};
        #1;
        chk("fwd_b_memwb_lane1", 0, int'(forward_b[2:0]), 4);
        mem_wb_first = 1'b1;
        #1;
        chk("fwd_b_memwb_lane0", 0, int'(forward_b[2:0]), 3);

        // r7 with latency 3: three stall cycles then clear, count 3.
        clear_in();
        issue0(7, 3);
        id_ex_rs[4:0] = 5'd7;
        step();
        issue_valid = '0;
        #1;
        chk("lat3_stall_c1", 0, int'(src_stall[0]), 1);
        step();
        chk("lat3_stall_c2", 0, int'(src_stall[0]), 1);
        step();
        chk("lat3_stall_c3", 0, int'(src_stall[0]), 1);
        step();
        chk("lat3_stall_done", 0, int'(src_stall[0]), 0);
        chk("lat3_stall_count", 0, int'(stall_count), 3);

        // Same rd in both lanes: lane1 latency 0 wins and clears.
        clear_in();
        issue_valid = 2'b11;
        issue_rd = {5'd9, 5'd9};
        issue_lat = {3'd0, 3'd4};
        id_ex_rs[4:0] = 5'd9;
        step();
        issue_valid = '0;
        #1;
        chk("same_rd_lat0_wins", 0, int'(src_stall[0]), 0);
        // Reverse: lane1 latency 2 wins over lane0 latency 0.
        issue_valid = 2'b11;
        issue_lat = {3'd2, 3'd0};
        step();
        issue_valid = '0;
        #1;
        chk("same_rd_lane1_sets", 0, int'(src_stall[0]), 1);
        step();
        step();
        chk("same_rd_lane1_done", 0, int'(src_stall[0]), 0);

        // Latency beyond MAX_LAT saturates to 4 cycles.
        clear_in();
        issue0(11, 7);
        id_ex_rt[9:5] = 5'd11;
        step();
        issue_valid = '0;
        step();
        step();
        step();
        chk("clamp_stall_c4", 1, int'(src_stall[1]), 1);
        step();
        chk("clamp_stall_done", 1, int'(src_stall[1]), 0);

        // Flush on the issue cycle wins.
        clear_in();
        issue0(4, 4);
        flush = 1'b1;
        id_ex_rs[4:0] = 5'd4;
        step();
        issue_valid = '0;
        flush = 1'b0;
        #1;
        chk("flush_beats_issue", 0, int'(src_stall[0]), 0);

        // Reset while countdown is at 2 clears stall at once and stays clear.
        issue0(4, 4);
        step();
        issue_valid = '0;
        step();
        step();
        chk("pre_reset_stall", 0, int'(src_stall[0]), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_stall", 0, int'(src_stall[0]), 0);
        chk("async_reset_count", 0, int'(stall_count), 0);
        #1;
        reset = 1'b0;
        step();
        chk("post_reset_stall", 0, int'(src_stall[0]), 0);

        // Continuous stall long enough to saturate the counter.
        clear_in();
        issue0(10, 4);
        id_ex_rs[4:0] = 5'd10;
        repeat (70000) step();
        chk("sat_count", 0, int'(stall_count), 65535);
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue_valid = '0;
        #1;
        chk("flush_keeps_count", 0, int'(stall_count), 65535);
        chk("flush_clears_stall", 0, int'(src_stall[0]), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
